// File: rtl/mem_scan_ram_pkg.sv
// Shared types and constants for the scanning RAM.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mem_scan_ram_pkg;

   // Sequencer states: IDLE serves direct reads, SCAN streams the address window.
   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } scan_state_t;

   // Read latency in cycles: the RAM read register plus the optional output stage.
   function automatic int rd_latency(input int out_reg);
      return 1 + out_reg;
   endfunction

endpackage

// File: rtl/mem_scan_ram_core.sv
// Plain 1W1R synchronous RAM, read-first on same-address collisions.
// Latency: 1 cycle from re to rd_data.
// Backpressure: none; one read and one write accepted every cycle.
module mem_scan_ram_core #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              re,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rd_data_d;
   logic [DATA_W-1:0] rd_data_q;

   // Storage array: no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   // Read mux samples the array before this edge's write lands (read-first); holds when idle.
   always_comb begin
      rd_data_d = rd_data_q;
      if (re) begin
         rd_data_d = mem_q[rd_addr];
      end
   end

   // Read data register; cleared by reset so the outputs start at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/mem_scan_ram.sv
// Writable RAM with direct reads and an autonomous address-window scan sequencer.
// Latency: 1 + OUT_REG cycles from issue to rd_valid.
// Backpressure: none; one word per clock in both direct and scan modes.
module mem_scan_ram
   import mem_scan_ram_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 4,
   parameter int OUT_REG = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              scan_start,
   input  logic              scan_stop,
   input  logic [ADDR_W-1:0] scan_first,
   input  logic [ADDR_W-1:0] scan_last,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic [ADDR_W-1:0] rd_tag,
   output logic              scan_busy,
   output logic              scan_wrap
);

   localparam int L = rd_latency(OUT_REG);

   scan_state_t       state_q, state_d;
   logic [ADDR_W-1:0] first_q, first_d;
   logic [ADDR_W-1:0] last_q, last_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              wrap_q, wrap_d;
   logic              vld1_q, vld1_d;
   logic [ADDR_W-1:0] tag1_q, tag1_d;
   logic              iss;
   logic [ADDR_W-1:0] iss_addr;
   logic [DATA_W-1:0] ram_data;

   // Next-state, pointer and read-issue decode. Start wins in IDLE, stop wins in SCAN.
   always_comb begin
      state_d  = state_q;
      first_d  = first_q;
      last_d   = last_q;
      ptr_d    = ptr_q;
      iss      = 1'b0;
      iss_addr = rd_addr;
      case (state_q)
         IDLE: begin
            iss = rd_en;
            if (scan_start) begin
               state_d = SCAN;
               first_d = scan_first;
               last_d  = scan_last;
               ptr_d   = scan_first;
            end
         end
         SCAN: begin
            if (scan_stop) begin
               state_d = IDLE;
            end else begin
               iss      = 1'b1;
               iss_addr = ptr_q;
               ptr_d    = (ptr_q == last_q) ? first_q : ptr_q + ADDR_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      // Wrap flag is registered so it is high exactly while the pointer sits on last.
      wrap_d = (state_d == SCAN) && (ptr_d == last_d);
      vld1_d = iss;
      tag1_d = iss ? iss_addr : tag1_q;
   end

   // Sequencer state, window bounds, pointer and first valid/tag stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         first_q <= '0;
         last_q  <= '0;
         ptr_q   <= '0;
         wrap_q  <= 1'b0;
         vld1_q  <= 1'b0;
         tag1_q  <= '0;
      end else begin
         state_q <= state_d;
         first_q <= first_d;
         last_q  <= last_d;
         ptr_q   <= ptr_d;
         wrap_q  <= wrap_d;
         vld1_q  <= vld1_d;
         tag1_q  <= tag1_d;
      end
   end

   mem_scan_ram_core #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_core (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (we),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .re      (iss),
      .rd_addr (iss_addr),
      .rd_data (ram_data)
   );

   if (L > 1) begin : g_out_reg
      logic              vld2_q, vld2_d;
      logic [ADDR_W-1:0] tag2_q, tag2_d;
      logic [DATA_W-1:0] data2_q, data2_d;

      // Output stage captures only valid words so data and tag hold between reads.
      always_comb begin
         vld2_d  = vld1_q;
         tag2_d  = vld1_q ? tag1_q : tag2_q;
         data2_d = vld1_q ? ram_data : data2_q;
      end

      // Output register stage.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld2_q  <= 1'b0;
            tag2_q  <= '0;
            data2_q <= '0;
         end else begin
            vld2_q  <= vld2_d;
            tag2_q  <= tag2_d;
            data2_q <= data2_d;
         end
      end

      assign rd_valid = vld2_q;
      assign rd_tag   = tag2_q;
      assign rd_data  = data2_q;
   end else begin : g_no_out_reg
      assign rd_valid = vld1_q;
      assign rd_tag   = tag1_q;
      assign rd_data  = ram_data;
   end

   assign scan_busy = (state_q == SCAN);
   assign scan_wrap = wrap_q;

endmodule

// File: tb/tb_mem_scan_ram.sv
// Self-checking bench for mem_scan_ram with the output register stage enabled.
// Latency: expectations are due L cycles after issue.
// Backpressure: none modelled; every expected word must appear on its due cycle.
`timescale 1ns/1ps
module tb_mem_scan_ram;

   localparam int DATA_W  = 16;
   localparam int ADDR_W  = 4;
   localparam int OUT_REG = 1;
   localparam int L       = 1 + OUT_REG;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              we = 1'b0;
   logic [ADDR_W-1:0] wr_addr = '0;
   logic [DATA_W-1:0] wr_data = '0;
   logic              rd_en = 1'b0;
   logic [ADDR_W-1:0] rd_addr = '0;
   logic              scan_start = 1'b0;
   logic              scan_stop = 1'b0;
   logic [ADDR_W-1:0] scan_first = '0;
   logic [ADDR_W-1:0] scan_last = '0;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic [ADDR_W-1:0] rd_tag;
   logic              scan_busy;
   logic              scan_wrap;

   typedef struct {
      int                due;
      logic [ADDR_W-1:0] tag;
      logic [DATA_W-1:0] data;
   } exp_t;

   exp_t              sb_q[$];
   exp_t              mon_e;
   exp_t              new_e;
   logic              mon_exp_vld;
   logic [DATA_W-1:0] model_mem [16];
   logic [ADDR_W-1:0] sc_first, sc_last, sc_ptr;
   int                cyc = 0;
   int                n_vec = 0;
   int                n_err = 0;

   mem_scan_ram #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .OUT_REG (OUT_REG)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .we         (we),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .scan_start (scan_start),
      .scan_stop  (scan_stop),
      .scan_first (scan_first),
      .scan_last  (scan_last),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .rd_tag     (rd_tag),
      .scan_busy  (scan_busy),
      .scan_wrap  (scan_wrap)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Scoreboard: every negedge, rd_valid must match whether an entry is due now.
   always @(negedge clk) begin
      mon_exp_vld = (sb_q.size() > 0) && (sb_q[0].due == cyc);
      check("rd_valid", 32'(rd_valid), 32'(mon_exp_vld));
      if (mon_exp_vld) begin
         mon_e = sb_q.pop_front();
         check("rd_tag", 32'(rd_tag), 32'(mon_e.tag));
         check("rd_data", 32'(rd_data), 32'(mon_e.data));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [ADDR_W-1:0] a);
      new_e.due  = cyc + L;
      new_e.tag  = a;
      new_e.data = model_mem[a];
      sb_q.push_back(new_e);
   endtask

   // One IDLE-mode cycle: optional write and optional direct read (read-first model).
   task automatic cycle_io(input logic w, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                           input logic r, input logic [ADDR_W-1:0] ra);
      we = w; wr_addr = wa; wr_data = wd; rd_en = r; rd_addr = ra;
      if (r) push_exp(ra);
      if (w) model_mem[wa] = wd;
      tick();
      we = 1'b0; rd_en = 1'b0;
   endtask

   task automatic scan_begin(input logic [ADDR_W-1:0] f, input logic [ADDR_W-1:0] l);
      scan_start = 1'b1; scan_first = f; scan_last = l;
      sc_first = f; sc_last = l; sc_ptr = f;
      tick();
      scan_start = 1'b0;
   endtask

   // One SCAN-mode cycle; a stray direct read request is driven and must be ignored.
   task automatic scan_issue();
      rd_en = 1'b1; rd_addr = 4'd9;
      check("scan_busy", 32'(scan_busy), 32'd1);
      check("scan_wrap", 32'(scan_wrap), 32'(sc_ptr == sc_last));
      push_exp(sc_ptr);
      sc_ptr = (sc_ptr == sc_last) ? sc_first : sc_ptr + 4'd1;
      tick();
      rd_en = 1'b0;
   endtask

   task automatic scan_end();
      scan_stop = 1'b1;
      check("busy_in_stop", 32'(scan_busy), 32'd1);
      tick();
      scan_stop = 1'b0;
      check("busy_after_stop", 32'(scan_busy), 32'd0);
      check("wrap_after_stop", 32'(scan_wrap), 32'd0);
   endtask

   initial begin
      // Reset state.
      #1 rst_n = 1'b0;
      #1;
      check("rst_rd_valid", 32'(rd_valid), 32'd0);
      check("rst_rd_data", 32'(rd_data), 32'd0);
      check("rst_rd_tag", 32'(rd_tag), 32'd0);
      check("rst_busy", 32'(scan_busy), 32'd0);
      check("rst_wrap", 32'(scan_wrap), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Fill: mem[i] = i, except addr 5 holds 0xAAAA.
      for (int i = 0; i < 16; i++) begin
         cycle_io(1'b1, 4'(i), (i == 5) ? 16'hAAAA : 16'(i), 1'b0, '0);
      end

      // Basic write then direct read of address 3.
      cycle_io(1'b1, 4'd3, 16'h1234, 1'b0, '0);
      cycle_io(1'b0, '0, '0, 1'b1, 4'd3);
      tick(); tick(); tick();

      // Same-address write and read: old word first, new word on the next read.
      cycle_io(1'b1, 4'd5, 16'hBEEF, 1'b1, 4'd5);
      cycle_io(1'b0, '0, '0, 1'b1, 4'd5);
      // Back-to-back direct reads.
      for (int i = 0; i < 4; i++) cycle_io(1'b0, '0, '0, 1'b1, 4'(i + 10));

      // Restore mem[i] = i for the scan windows.
      cycle_io(1'b1, 4'd3, 16'd3, 1'b0, '0);
      cycle_io(1'b1, 4'd5, 16'd5, 1'b0, '0);

      // Window 2..5 for 10 cycles, then stop.
      scan_begin(4'd2, 4'd5);
      for (int i = 0; i < 10; i++) scan_issue();
      scan_end();
      tick(); tick(); tick();

      // Window wrapping through 15 -> 0.
      scan_begin(4'd14, 4'd1);
      for (int i = 0; i < 6; i++) scan_issue();
      scan_end();

      // Single-address window: wrap stays high.
      scan_begin(4'd7, 4'd7);
      for (int i = 0; i < 3; i++) scan_issue();
      scan_end();
      tick(); tick();

      // Start and stop together in IDLE: start wins; together in SCAN: stop wins.
      scan_stop = 1'b1;
      scan_begin(4'd8, 4'd9);
      scan_stop = 1'b0;
      scan_issue();
      scan_start = 1'b1; scan_stop = 1'b1; scan_first = 4'd0;
      tick();
      scan_start = 1'b0; scan_stop = 1'b0;
      check("stop_wins", 32'(scan_busy), 32'd0);
      tick(); tick(); tick();

      // Reset mid-scan flushes everything in flight.
      scan_begin(4'd0, 4'd15);
      for (int i = 0; i < 4; i++) scan_issue();
      rst_n = 1'b0;
      sb_q.delete();
      #1;
      check("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
      check("mid_rst_rd_data", 32'(rd_data), 32'd0);
      check("mid_rst_rd_tag", 32'(rd_tag), 32'd0);
      check("mid_rst_busy", 32'(scan_busy), 32'd0);
      check("mid_rst_wrap", 32'(scan_wrap), 32'd0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      check("post_rst_busy", 32'(scan_busy), 32'd0);

      // Memory survives reset.
      cycle_io(1'b0, '0, '0, 1'b1, 4'd12);
      for (int i = 0; i < 4; i++) tick();
      check("sb_drain", 32'(sb_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
